vga_timing_detector: RTL and testbench

VGA_TIMING_DETECTOR -- requirements
Module: vga_timing_detector

---
 rtl/vga_timing_detector.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_vga_timing_detector.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_detector.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_detector
// Purpose  : Measures the horizontal and vertical timing of an incoming VGA
//            sync/blank stream, reports it once per frame and flags when the
//            timing has been stable for LOCK_FRAMES consecutive frames.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   W            width of every counter and measurement output
//   LOCK_FRAMES  consecutive identical frames needed for lock (2..15)
// Ports
//   pixel_clk    in   pixel clock, rising edge
//   reset        in   synchronous active-high reset
//   vga_hs       in   horizontal sync, active low
//   vga_vs       in   vertical sync, active low
//   vga_blank    in   high = active video
//   h_total/h_sync/h_disp  out  pixels per line: period, sync width, active
//   v_total/v_sync/v_disp  out  lines per frame: period, sync, active
//   frame_strobe out   one-cycle pulse when the measurements update
//   locked       out   timing stable
//   err          out   a counter saturated; cleared by the next valid frame
// Optional build macro
//   VGA_TIMING_DET_POS_EN adds pos_x/pos_y/pos_valid (active-video position)
// ============================================================================
module vga_timing_detector #(
  parameter int W           = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          pixel_clk,
  input  logic          reset,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank,
  output logic [W-1:0]  h_total,
  output logic [W-1:0]  h_sync,
  output logic [W-1:0]  h_disp,
  output logic [W-1:0]  v_total,
  output logic [W-1:0]  v_sync,
  output logic [W-1:0]  v_disp,
  output logic          frame_strobe,
  output logic          locked,
  output logic          err
`ifdef VGA_TIMING_DET_POS_EN
  ,
  output logic [W-1:0]  pos_x,
  output logic [W-1:0]  pos_y,
  output logic          pos_valid
`endif
);

  localparam logic [W-1:0] C_MAX  = {W{1'b1}};
  localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [3:0]   C_LOCK = LOCK_FRAMES[3:0];

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // two-stage input registers
  logic r_hs1, r_hs2, r_vs1, r_vs2, r_bl1, r_bl2;

  // per-line counters and the lines they are latched into
  logic [W-1:0] r_h_cnt, r_hs_cnt, r_bl_cnt;
  logic [W-1:0] r_ll_h, r_ll_hs, r_ll_bl;     // last completed line
  logic [W-1:0] r_la_h, r_la_hs, r_la_bl;     // last completed active line
  logic         r_la_valid;

  // per-frame counters
  logic [W-1:0] r_ln_cnt, r_vs_cnt, r_act_cnt;

  // frame snapshot taken at frame start, published one cycle later
  logic [W-1:0] r_snap_h, r_snap_hs, r_snap_bl, r_snap_ln, r_snap_vs, r_snap_act;
  logic         r_pend;

  state_t       r_state;
  logic [3:0]   r_match_cnt;

  logic         w_line_start, w_frame_start, w_sat, w_closing_act, w_tuple_eq;
  logic [W-1:0] w_fr_h, w_fr_hs, w_fr_bl, w_fr_act;
  logic [3:0]   w_next_match;

  assign w_line_start  = r_hs2 & ~r_hs1;
  assign w_frame_start = r_vs2 & ~r_vs1;

  // The cycle in which a line start is seen belongs to the new line, so the
  // counters at that moment hold the complete previous line.
  assign w_closing_act = w_line_start && (r_bl_cnt != '0);

  // hs/bl counts never exceed h_cnt and vs/act never exceed ln_cnt, so only
  // the two period counters can run out of range.
  assign w_sat = ((r_h_cnt == C_MAX) && !w_line_start) ||
                 ((r_ln_cnt == C_MAX) && w_line_start && !w_frame_start);

  // A line closing at the frame start still belongs to the old frame.
  assign w_fr_act = r_act_cnt + {{(W-1){1'b0}}, w_closing_act};

  always_comb begin
    w_fr_h  = r_ll_h;
    w_fr_hs = r_ll_hs;
    w_fr_bl = r_ll_bl;
    if (w_closing_act) begin
      w_fr_h  = r_h_cnt;
      w_fr_hs = r_hs_cnt;
      w_fr_bl = r_bl_cnt;
    end else if (r_la_valid) begin
      w_fr_h  = r_la_h;
      w_fr_hs = r_la_hs;
      w_fr_bl = r_la_bl;
    end else if (w_line_start) begin
      w_fr_h  = r_h_cnt;
      w_fr_hs = r_hs_cnt;
      w_fr_bl = r_bl_cnt;
    end
  end

  assign w_tuple_eq = ({r_snap_h, r_snap_hs, r_snap_bl, r_snap_ln, r_snap_vs, r_snap_act} ==
                       {h_total, h_sync, h_disp, v_total, v_sync, v_disp});

  always_comb begin
    if (!w_tuple_eq) begin
      w_next_match = 4'd1;
    end else if (r_match_cnt < C_LOCK) begin
      w_next_match = r_match_cnt + 4'd1;
    end else begin
      w_next_match = r_match_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // Input pipeline and measurement counters
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_hs1      <= 1'b0;
      r_hs2      <= 1'b0;
      r_vs1      <= 1'b0;
      r_vs2      <= 1'b0;
      r_bl1      <= 1'b0;
      r_bl2      <= 1'b0;
      r_h_cnt    <= '0;
      r_hs_cnt   <= '0;
      r_bl_cnt   <= '0;
      r_ll_h     <= '0;
      r_ll_hs    <= '0;
      r_ll_bl    <= '0;
      r_la_h     <= '0;
      r_la_hs    <= '0;
      r_la_bl    <= '0;
      r_la_valid <= 1'b0;
      r_ln_cnt   <= '0;
      r_vs_cnt   <= '0;
      r_act_cnt  <= '0;
    end else begin
      r_hs1 <= vga_hs;
      r_hs2 <= r_hs1;
      r_vs1 <= vga_vs;
      r_vs2 <= r_vs1;
      r_bl1 <= vga_blank;
      r_bl2 <= r_bl1;

      // Sync-low and blank-high levels are counted from stage 2; that copy
      // trails the line boundary by one cycle but still lies inside the line.
      if (w_line_start) begin
        r_h_cnt  <= C_ONE;
        r_hs_cnt <= {{(W-1){1'b0}}, ~r_hs2};
        r_bl_cnt <= {{(W-1){1'b0}}, r_bl2};
        r_ll_h   <= r_h_cnt;
        r_ll_hs  <= r_hs_cnt;
        r_ll_bl  <= r_bl_cnt;
        if (r_bl_cnt != '0) begin
          r_la_h     <= r_h_cnt;
          r_la_hs    <= r_hs_cnt;
          r_la_bl    <= r_bl_cnt;
          r_la_valid <= 1'b1;
        end
      end else if (r_h_cnt != C_MAX) begin
        r_h_cnt  <= r_h_cnt + C_ONE;
        r_hs_cnt <= r_hs_cnt + {{(W-1){1'b0}}, ~r_hs2};
        r_bl_cnt <= r_bl_cnt + {{(W-1){1'b0}}, r_bl2};
      end

      // A coincident line start is line 1 of the new frame; vs is low at a
      // frame start, so that line also counts as a sync line.
      if (w_frame_start) begin
        r_ln_cnt   <= {{(W-1){1'b0}}, w_line_start};
        r_vs_cnt   <= {{(W-1){1'b0}}, w_line_start};
        r_act_cnt  <= '0;
        r_la_valid <= 1'b0;
      end else if (w_line_start && (r_ln_cnt != C_MAX)) begin
        r_ln_cnt  <= r_ln_cnt + C_ONE;
        r_vs_cnt  <= r_vs_cnt + {{(W-1){1'b0}}, ~r_vs1};
        r_act_cnt <= r_act_cnt + {{(W-1){1'b0}}, (r_bl_cnt != '0)};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lock state machine and measurement outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_state      <= ST_SEARCH;
      r_match_cnt  <= '0;
      r_pend       <= 1'b0;
      r_snap_h     <= '0;
      r_snap_hs    <= '0;
      r_snap_bl    <= '0;
      r_snap_ln    <= '0;
      r_snap_vs    <= '0;
      r_snap_act   <= '0;
      h_total      <= '0;
      h_sync       <= '0;
      h_disp       <= '0;
      v_total      <= '0;
      v_sync       <= '0;
      v_disp       <= '0;
      frame_strobe <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;

      // locked rises the cycle after entering LOCKED but falls together with
      // the strobe that reports a mismatch.
      if (r_state == ST_LOCKED) begin
        locked <= 1'b1;
      end

      if (w_sat) begin
        err         <= 1'b1;
        locked      <= 1'b0;
        r_state     <= ST_SEARCH;
        r_pend      <= 1'b0;
        r_match_cnt <= '0;
      end else begin
        if (r_pend) begin
          r_pend       <= 1'b0;
          h_total      <= r_snap_h;
          h_sync       <= r_snap_hs;
          h_disp       <= r_snap_bl;
          v_total      <= r_snap_ln;
          v_sync       <= r_snap_vs;
          v_disp       <= r_snap_act;
          frame_strobe <= 1'b1;
          err          <= 1'b0;
          r_match_cnt  <= w_next_match;
          case (r_state)
            ST_MEASURE: begin
              if (w_next_match >= C_LOCK) begin
                r_state <= ST_LOCKED;
              end
            end
            ST_LOCKED: begin
              if (!w_tuple_eq) begin
                locked  <= 1'b0;
                r_state <= ST_MEASURE;
              end
            end
            default: begin
            end
          endcase
        end

        if (w_frame_start) begin
          if (r_state == ST_SEARCH) begin
            r_state <= ST_MEASURE;
            err     <= 1'b0;
          end else begin
            r_snap_h   <= w_fr_h;
            r_snap_hs  <= w_fr_hs;
            r_snap_bl  <= w_fr_bl;
            r_snap_ln  <= r_ln_cnt;
            r_snap_vs  <= r_vs_cnt;
            r_snap_act <= w_fr_act;
            r_pend     <= 1'b1;
          end
        end
      end
    end
  end

`ifdef VGA_TIMING_DET_POS_EN
  // --------------------------------------------------------------------------
  // Active-video position, aligned to the stage-2 blank signal
  // --------------------------------------------------------------------------
  logic w_bl_fall;
  logic r_line_seen;   // first active span of this line already counted

  assign w_bl_fall = r_bl2 & ~r_bl1;
  assign pos_valid = r_bl2;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      pos_x       <= '0;
      pos_y       <= '0;
      r_line_seen <= 1'b0;
    end else begin
      if (w_bl_fall) begin
        pos_x <= '0;
      end else if (r_bl2) begin
        pos_x <= pos_x + C_ONE;
      end

      if (w_frame_start) begin
        pos_y <= '0;
      end else if (w_bl_fall && !r_line_seen) begin
        pos_y <= pos_y + C_ONE;
      end

      if (w_line_start) begin
        r_line_seen <= 1'b0;
      end
      if (w_bl_fall) begin
        r_line_seen <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_detector
// Purpose  : Directed self-checking bench for vga_timing_detector using a
//            reduced video mode so several frames fit in a short run.
//            Mode: h 32 active / 4 fp / 8 sync / 4 bp  (48 total)
//                  v 24 active / 3 fp / 2 sync / 4 bp  (33 total)
//            Each generated frame starts with its sync line, vs and hs
//            falling in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_timing_detector;

  localparam int W = 12;

  logic          pixel_clk = 1'b0;
  logic          reset;
  logic          vga_hs, vga_vs, vga_blank;
  logic [W-1:0]  h_total, h_sync, h_disp, v_total, v_sync, v_disp;
  logic          frame_strobe, locked, err;
`ifdef VGA_TIMING_DET_POS_EN
  logic [W-1:0]  pos_x, pos_y;
  logic          pos_valid;
`endif

  vga_timing_detector #(.W(W), .LOCK_FRAMES(2)) dut (
    .pixel_clk    (pixel_clk),
    .reset        (reset),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_blank    (vga_blank),
    .h_total      (h_total),
    .h_sync       (h_sync),
    .h_disp       (h_disp),
    .v_total      (v_total),
    .v_sync       (v_sync),
    .v_disp       (v_disp),
    .frame_strobe (frame_strobe),
    .locked       (locked),
    .err          (err)
`ifdef VGA_TIMING_DET_POS_EN
    ,
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .pos_valid    (pos_valid)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks   = 0;
  int failures = 0;

  // values captured on every strobe cycle
  int           strobe_cnt = 0;
  logic [W-1:0] st_ht, st_hs, st_hd, st_vt, st_vs, st_vd;
  logic         st_locked;

  always @(negedge pixel_clk) begin
    if (frame_strobe === 1'b1) begin
      strobe_cnt++;
      st_ht     = h_total;
      st_hs     = h_sync;
      st_hd     = h_disp;
      st_vt     = v_total;
      st_vs     = v_sync;
      st_vd     = v_disp;
      st_locked = locked;
    end
  end

`ifdef VGA_TIMING_DET_POS_EN
  int           pv_cnt = 0;
  logic [W-1:0] pv_max_x = '0, pv_max_y = '0, pv_first_x = '0;
  always @(negedge pixel_clk) begin
    if (pos_valid === 1'b1) begin
      if (pv_cnt == 0) pv_first_x = pos_x;
      pv_cnt++;
      if (pos_x > pv_max_x) pv_max_x = pos_x;
      if (pos_y > pv_max_y) pv_max_y = pos_y;
    end
  end
`endif

  // one pixel: inputs change on the falling edge, DUT samples on the rising
  task automatic px(input logic hs, input logic vs, input logic bl);
    @(negedge pixel_clk);
    vga_hs    = hs;
    vga_vs    = vs;
    vga_blank = bl;
  endtask

  task automatic send_line(input int fp, input logic vs_low, input logic act);
    for (int c = 0; c < 44 + fp; c++) begin
      px((c < 8) ? 1'b0 : 1'b1, ~vs_low, act && (c >= 12) && (c < 44));
    end
  endtask

  task automatic send_frame(input int fp, input int nlines);
    for (int l = 0; l < nlines; l++) begin
      send_line(fp, l < 2, (l >= 6) && (l < 30));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) px(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    repeat (4) px(1'b1, 1'b1, 1'b0);
    checks++;
    if ({h_total, h_sync, h_disp, v_total, v_sync, v_disp} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %0d/%0d/%0d/%0d/%0d/%0d expected all 0",
               h_total, h_sync, h_disp, v_total, v_sync, v_disp);
    end
    checks++;
    if (frame_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b expected 0", frame_strobe); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", locked); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_lock_acquire();
    send_frame(4, 33);
    checks++;
    if (strobe_cnt != 0) begin failures++; $display("FAIL search_no_strobe: got %0d strobes expected 0", strobe_cnt); end
    send_frame(4, 33);
    checks++;
    if (strobe_cnt != 1) begin failures++; $display("FAIL first_strobe: got %0d strobes expected 1", strobe_cnt); end
    send_frame(4, 33);
    checks++;
    if (strobe_cnt != 2) begin failures++; $display("FAIL second_strobe: got %0d strobes expected 2", strobe_cnt); end
    checks++;
    if (st_ht !== 12'd48) begin failures++; $display("FAIL h_total: got %0d expected 48", st_ht); end
    checks++;
    if (st_hs !== 12'd8) begin failures++; $display("FAIL h_sync: got %0d expected 8", st_hs); end
    checks++;
    if (st_hd !== 12'd32) begin failures++; $display("FAIL h_disp: got %0d expected 32", st_hd); end
    checks++;
    if (st_vt !== 12'd33) begin failures++; $display("FAIL v_total_coincident: got %0d expected 33", st_vt); end
    checks++;
    if (st_vs !== 12'd2) begin failures++; $display("FAIL v_sync: got %0d expected 2", st_vs); end
    checks++;
    if (st_vd !== 12'd24) begin failures++; $display("FAIL v_disp: got %0d expected 24", st_vd); end
    checks++;
    if (st_locked !== 1'b0) begin failures++; $display("FAIL locked_at_2nd_strobe: got %b expected 0", st_locked); end
    send_frame(4, 33);
    checks++;
    if (st_locked !== 1'b1) begin failures++; $display("FAIL locked_at_3rd_strobe: got %b expected 1", st_locked); end
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL locked_hold: got %b expected 1", locked); end
  endtask

  task automatic test_htotal_change();
    int base;
    base = strobe_cnt;
    send_frame(5, 33);
    send_frame(5, 33);
    checks++;
    if (strobe_cnt != base + 2) begin failures++; $display("FAIL change_strobes: got %0d expected %0d", strobe_cnt, base + 2); end
    checks++;
    if (st_ht !== 12'd49) begin failures++; $display("FAIL change_h_total: got %0d expected 49", st_ht); end
    checks++;
    if (st_locked !== 1'b0) begin failures++; $display("FAIL change_unlock: got %b expected 0", st_locked); end
    checks++;
    if ({st_hs, st_hd, st_vt} !== {12'd8, 12'd32, 12'd33}) begin
      failures++;
      $display("FAIL change_others: got %0d/%0d/%0d expected 8/32/33", st_hs, st_hd, st_vt);
    end
    send_frame(5, 33);
    checks++;
    if (locked !== 1'b1) begin failures++; $display("FAIL relock: got %b expected 1", locked); end
  endtask

  task automatic test_saturation();
    int base;
    base = strobe_cnt;
    repeat (8) px(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4100; i++) begin
      px(1'b1, 1'b1, 1'b0);
      if (i == 3800) begin
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL sat_early_err: got %b expected 0", err); end
      end
    end
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL sat_err: got %b expected 1", err); end
    checks++;
    if (locked !== 1'b0) begin failures++; $display("FAIL sat_locked: got %b expected 0", locked); end
    send_frame(4, 33);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL sat_err_clear: got %b expected 0", err); end
    checks++;
    if (strobe_cnt != base) begin failures++; $display("FAIL sat_no_strobe: got %0d expected %0d", strobe_cnt, base); end
    checks++;
    if (h_total !== 12'd49) begin failures++; $display("FAIL sat_hold: got %0d expected 49", h_total); end
    send_frame(4, 33);
    checks++;
    if (strobe_cnt != base + 1) begin failures++; $display("FAIL sat_recover_strobe: got %0d expected %0d", strobe_cnt, base + 1); end
    checks++;
    if ({st_ht, st_locked} !== {12'd48, 1'b0}) begin
      failures++;
      $display("FAIL sat_recover_vals: got h_total=%0d locked=%b expected 48/0", st_ht, st_locked);
    end
  endtask

  task automatic test_reset_midframe();
    int base;
    send_frame(4, 10);
    px(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    px(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    checks++;
    if ({h_total, h_sync, h_disp, v_total, v_sync, v_disp, frame_strobe, locked, err} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got h_total=%0d v_total=%0d strobe=%b locked=%b err=%b expected all 0",
               h_total, v_total, frame_strobe, locked, err);
    end
    repeat (4) px(1'b1, 1'b1, 1'b0);
    base = strobe_cnt;
    send_frame(4, 33);
    checks++;
    if (strobe_cnt != base) begin failures++; $display("FAIL midreset_no_strobe: got %0d expected %0d", strobe_cnt, base); end
    send_frame(4, 33);
    checks++;
    if (strobe_cnt != base + 1) begin failures++; $display("FAIL midreset_strobe: got %0d expected %0d", strobe_cnt, base + 1); end
    checks++;
    if ({st_ht, st_hs, st_hd, st_vt, st_vs, st_vd} !== {12'd48, 12'd8, 12'd32, 12'd33, 12'd2, 12'd24}) begin
      failures++;
      $display("FAIL midreset_vals: got %0d/%0d/%0d/%0d/%0d/%0d expected 48/8/32/33/2/24",
               st_ht, st_hs, st_hd, st_vt, st_vs, st_vd);
    end
  endtask

`ifdef VGA_TIMING_DET_POS_EN
  task automatic test_pos();
    pv_cnt   = 0;
    pv_max_x = '0;
    pv_max_y = '0;
    send_frame(4, 33);
    checks++;
    if (pv_cnt != 768) begin failures++; $display("FAIL pos_valid_count: got %0d expected 768", pv_cnt); end
    checks++;
    if (pv_first_x !== 12'd0) begin failures++; $display("FAIL pos_x_first: got %0d expected 0", pv_first_x); end
    checks++;
    if (pv_max_x !== 12'd31) begin failures++; $display("FAIL pos_x_max: got %0d expected 31", pv_max_x); end
    checks++;
    if (pv_max_y !== 12'd23) begin failures++; $display("FAIL pos_y_max: got %0d expected 23", pv_max_y); end
  endtask
`endif

  initial begin
    reset     = 1'b1;
    vga_hs    = 1'b1;
    vga_vs    = 1'b1;
    vga_blank = 1'b0;
    test_reset();
    test_lock_acquire();
    test_htotal_change();
    test_saturation();
    test_reset_midframe();
`ifdef VGA_TIMING_DET_POS_EN
    test_pos();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
